// File: rtl/ans_table_dumper_if.sv
// Nibble stream from the ANS table dumper: registered data beat with valid/ready.
interface ans_table_dumper_if #(
  parameter int CNT_WIDTH = 4
);
  logic [CNT_WIDTH-1:0] out;
  logic                 out_vld;
  logic                 out_rdy;

  modport master (output out, output out_vld, input out_rdy);
  modport slave  (input out, input out_vld, output out_rdy);
endinterface

// File: rtl/ans_table_dumper.sv
// Snapshots the ANS count table and streams it as raw counts or cumulative
// start offsets (low/high nibble per entry), closed by an XOR checksum beat.
module ans_table_dumper #(
  parameter int SYM_WIDTH = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [CNT_WIDTH*(2**SYM_WIDTH)-1:0]  counts_unpacked,
  input  logic                                 start,
  input  logic                                 cum_mode,
  output logic                                 busy,
  output logic                                 done,
  ans_table_dumper_if.master                   dout
);
  localparam int SYM_COUNT = 2**SYM_WIDTH;
  localparam int ACC_W     = 2*CNT_WIDTH;

  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;

  state_t                             state_q, state_d;
  logic [SYM_COUNT-1:0][CNT_WIDTH-1:0] snap_q;
  logic                               mode_q;
  logic [SYM_WIDTH-1:0]               idx_q;
  logic                               half_q;
  logic [ACC_W-1:0]                   acc_q;
  logic [CNT_WIDTH-1:0]               csum_q;
  logic [CNT_WIDTH-1:0]               out_q;
  logic                               vld_q;
  logic                               done_q;

  logic                 accept, last;
  logic [SYM_WIDTH-1:0] idx_inc;
  logic [ACC_W-1:0]     acc_nx;
  logic [CNT_WIDTH-1:0] csum_nx, nx_beat;

  // idx/half/acc always describe the beat currently on out_q
  always_comb begin
    accept  = vld_q && dout.out_rdy;
    last    = (idx_q == '1) && (half_q || !mode_q);
    idx_inc = idx_q + 1'b1;
    acc_nx  = acc_q + ACC_W'(snap_q[idx_q]);
    csum_nx = csum_q ^ out_q;
    nx_beat = snap_q[idx_inc];
    if (mode_q) nx_beat = half_q ? acc_nx[CNT_WIDTH-1:0] : acc_q[ACC_W-1:CNT_WIDTH];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SEND;
      SEND:    if (accept && last) state_d = CSUM;
      CSUM:    if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
      mode_q <= 1'b0;
      idx_q  <= '0;
      half_q <= 1'b0;
      acc_q  <= '0;
      csum_q <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          snap_q <= counts_unpacked;
          mode_q <= cum_mode;
          idx_q  <= '0;
          half_q <= 1'b0;
          acc_q  <= '0;
          csum_q <= '0;
          vld_q  <= 1'b1;
          out_q  <= cum_mode ? '0 : counts_unpacked[CNT_WIDTH-1:0];
        end
        SEND: if (accept) begin
          csum_q <= csum_nx;
          if (last) out_q <= csum_nx;
          else begin
            out_q <= nx_beat;
            if (mode_q && !half_q) half_q <= 1'b1;
            else begin
              half_q <= 1'b0;
              idx_q  <= idx_inc;
              if (mode_q) acc_q <= acc_nx;
            end
          end
        end
        CSUM: if (accept) begin
          vld_q  <= 1'b0;
          out_q  <= '0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign dout.out     = out_q;
  assign dout.out_vld = vld_q;
endmodule

// File: tb/tb_ans_table_dumper.sv
// Directed bench for ans_table_dumper: raw/cumulative dumps, backpressure,
// snapshot isolation, ignored start, back-to-back dumps and mid-dump reset.
module tb_ans_table_dumper;
  localparam int SW = 4;
  localparam int CW = 4;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [CW*N-1:0] counts;
  logic start, cum_mode, busy, done;

  ans_table_dumper_if #(.CNT_WIDTH(CW)) dif ();

  ans_table_dumper #(.SYM_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .counts_unpacked(counts), .start(start),
    .cum_mode(cum_mode), .busy(busy), .done(done), .dout(dif.master)
  );

  int total = 0;
  int fails = 0;
  logic [3:0] exp_b [64];
  logic [3:0] obs   [64];
  int n_beats;

  task automatic chk(string tag, string what, logic [7:0] got, logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s_%s: observed %h expected %h", tag, what, got, exp);
    end
  endtask

  // reference beat list for the current counts table
  function automatic void build_exp(bit cm);
    logic [7:0] acc;
    logic [3:0] cs;
    logic [3:0] c;
    int k;
    acc = '0; cs = '0; k = 0;
    for (int i = 0; i < N; i++) begin
      c = counts[i*CW +: CW];
      if (!cm) begin
        exp_b[k] = c; cs ^= c; k++;
      end else begin
        exp_b[k] = acc[3:0]; cs ^= acc[3:0]; k++;
        exp_b[k] = acc[7:4]; cs ^= acc[7:4]; k++;
        acc = acc + {4'h0, c};
      end
    end
    exp_b[k] = cs;
    n_beats  = k + 1;
  endfunction

  task automatic fill_idx();
    for (int i = 0; i < N; i++) counts[i*CW +: CW] = 4'(i);
  endtask

  task automatic start_dump(bit cm);
    start = 1'b1; cum_mode = cm;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_stream(string tag, int stall_at, int zero_at, int start_at,
                            int abort_at, bit b2b);
    for (int k = 0; k < n_beats; k++) begin
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk(tag, "rst_busy", 8'(busy), 8'h0);
        chk(tag, "rst_vld",  8'(dif.out_vld), 8'h0);
        chk(tag, "rst_done", 8'(done), 8'h0);
        chk(tag, "rst_out",  8'(dif.out), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k == zero_at) counts = '0;
      start = (k == start_at);
      if (k == stall_at) begin
        dif.out_rdy = 1'b0;
        repeat (3) begin
          chk(tag, "stall_vld", 8'(dif.out_vld), 8'h1);
          chk(tag, "stall_out", 8'(dif.out), 8'(exp_b[k]));
          @(negedge clk);
        end
        dif.out_rdy = 1'b1;
      end
      chk(tag, "vld",  8'(dif.out_vld), 8'h1);
      chk(tag, "out",  8'(dif.out), 8'(exp_b[k]));
      chk(tag, "busy", 8'(busy), 8'h1);
      obs[k] = dif.out;
      @(negedge clk);
    end
    start = 1'b0;
    chk(tag, "done",     8'(done), 8'h1);
    chk(tag, "end_busy", 8'(busy), 8'h0);
    chk(tag, "end_vld",  8'(dif.out_vld), 8'h0);
    chk(tag, "end_out",  8'(dif.out), 8'h0);
    if (b2b) begin
      build_exp(cum_mode);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end else begin
      @(negedge clk);
      chk(tag, "done_pulse", 8'(done), 8'h0);
      chk(tag, "idle_vld", 8'(dif.out_vld), 8'h0);
    end
  endtask

  initial begin
    counts = '0; start = 1'b0; cum_mode = 1'b0; dif.out_rdy = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset", "busy", 8'(busy), 8'h0);
    chk("reset", "vld",  8'(dif.out_vld), 8'h0);
    chk("reset", "out",  8'(dif.out), 8'h0);
    chk("reset", "done", 8'(done), 8'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // raw, count[i]=i
    fill_idx(); build_exp(1'b0);
    chk("raw", "pre_vld", 8'(dif.out_vld), 8'h0);
    start_dump(1'b0);
    run_stream("raw", -1, -1, -1, -1, 1'b0);
    chk("raw", "b15", 8'(obs[15]), 8'h0F);
    chk("raw", "csum", 8'(obs[16]), 8'h00);

    // cumulative, count[0]=5
    counts = '0; counts[3:0] = 4'h5; build_exp(1'b1);
    start_dump(1'b1);
    run_stream("cum5", -1, -1, -1, -1, 1'b0);
    chk("cum5", "b1", 8'(obs[1]), 8'h0);
    chk("cum5", "b2", 8'(obs[2]), 8'h5);
    chk("cum5", "b3", 8'(obs[3]), 8'h0);
    chk("cum5", "csum", 8'(obs[32]), 8'h5);

    // all counts 15, cumulative then raw
    counts = '1; build_exp(1'b1);
    start_dump(1'b1);
    run_stream("cumF", -1, -1, -1, -1, 1'b0);
    chk("cumF", "e15_lo", 8'(obs[30]), 8'h1);
    chk("cumF", "e15_hi", 8'(obs[31]), 8'hE);
    build_exp(1'b0);
    start_dump(1'b0);
    run_stream("rawF", -1, -1, -1, -1, 1'b0);
    chk("rawF", "b0", 8'(obs[0]), 8'hF);
    chk("rawF", "csum", 8'(obs[16]), 8'h0);

    // backpressure at beat 2
    fill_idx(); build_exp(1'b0);
    start_dump(1'b0);
    run_stream("bp", 2, -1, -1, -1, 1'b0);

    // snapshot isolation, ignored start, back-to-back launch from done cycle
    fill_idx(); build_exp(1'b0);
    start_dump(1'b0);
    run_stream("snap", -1, 4, 6, -1, 1'b1);
    run_stream("b2b", -1, -1, -1, -1, 1'b0);
    chk("b2b", "b5", 8'(obs[5]), 8'h0);

    // reset mid-dump, then a clean dump
    fill_idx(); build_exp(1'b0);
    start_dump(1'b0);
    run_stream("abort", -1, -1, -1, 7, 1'b0);
    chk("abort", "post_vld", 8'(dif.out_vld), 8'h0);
    chk("abort", "post_done", 8'(done), 8'h0);
    start_dump(1'b0);
    run_stream("after", -1, -1, -1, -1, 1'b0);
    chk("after", "b7", 8'(obs[7]), 8'h7);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
